// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode/func constants and the decoded ALU command type
package riscv_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef struct packed {
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  func3;
    logic        subsra;
    logic [4:0]  rd;
    logic        wr_en;
    logic        illegal;
  } alu_cmd_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I-type and U-type immediates from the upper instruction bits
module imm_gen (
  input  logic [31:12] instr,
  output logic [31:0]  imm_i,
  output logic [31:0]  imm_u
);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: one-entry decode stage producing registered ALU commands
module alu_decode_stage
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      operand1,
  output logic [31:0]      operand2,
  output logic [2:0]       func3,
  output logic             subsra,
  output logic [4:0]       rd,
  output logic             wr_en,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);
  alu_cmd_t dec, cmd;
  logic [31:0] imm_i, imm_u;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic shift, legal;
  imm_gen u_imm (.instr(in_instr[31:12]), .imm_i(imm_i), .imm_u(imm_u));
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign shift = f3 == F3_SLL || f3 == F3_SR;
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign in_ready = !out_valid || out_ready;
  // decode the presented instruction; illegal encodings collapse to a zeroed trap command
  always_comb begin
    dec = '0;
    dec.rd = in_instr[11:7];
    legal = 1'b0;
    case (opc)
      OPC_OP: begin
        legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        dec.operand1 = rs1_data;
        dec.operand2 = shift ? {27'b0, rs2_data[4:0]} : rs2_data;
        dec.func3 = f3;
        dec.subsra = in_instr[30];
      end
      OPC_OP_IMM: begin
        legal = f3 == F3_SLL ? f7 == F7_BASE : f3 == F3_SR ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        dec.operand1 = rs1_data;
        dec.operand2 = shift ? {27'b0, in_instr[24:20]} : imm_i;
        dec.func3 = f3;
        dec.subsra = f3 == F3_SR && in_instr[30];
      end
      OPC_LUI: begin
        legal = 1'b1;
        dec.operand2 = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        dec.operand1 = in_pc;
        dec.operand2 = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.operand1 = '0;
      dec.operand2 = '0;
      dec.func3 = F3_ADD;
      dec.subsra = 1'b0;
    end
    dec.illegal = !legal;
    dec.wr_en = legal && dec.rd != 5'd0;
  end
  // output register: loads on accept, holds under backpressure, flush drops the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd <= '0;
      out_valid <= 1'b0;
      dec_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        cmd <= dec;
        dec_count <= dec_count + CNT_W'(1);
      end
    end
  end
  assign operand1 = cmd.operand1;
  assign operand2 = cmd.operand2;
  assign func3 = cmd.func3;
  assign subsra = cmd.subsra;
  assign rd = cmd.rd;
  assign wr_en = cmd.wr_en;
  assign illegal = cmd.illegal;
endmodule
